// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_LOAD_OVF = 2'd1;
  localparam logic [1:0] FAULT_MISALIGN = 2'd2;
  localparam logic [1:0] FAULT_RANGE    = 2'd3;

  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

  // A byte address is in range when no bit above the word-address field is set.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/fetch_seq_pc_next_sel.sv
// Combinational next-pc selection: stall > jump > branch > sequential,
// with alignment and range checks on the selected candidate.
module pc_next_sel
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_d_o,
  output logic [1:0]  fault_o
);

  logic [32:0] seq_sum;
  logic [31:0] cand;
  logic        redirect;
  logic        cand_carry;

  assign seq_sum = {1'b0, pc_i} + 33'd4;

  always_comb begin
    cand       = seq_sum[31:0];
    cand_carry = seq_sum[32];
    redirect   = 1'b0;
    if (jump_i) begin
      cand       = jump_target_i;
      cand_carry = 1'b0;
      redirect   = 1'b1;
    end else if (branch_taken_i) begin
      cand       = branch_target_i;
      cand_carry = 1'b0;
      redirect   = 1'b1;
    end

    pc_d_o  = pc_i;
    fault_o = FAULT_NONE;
    // A sequential step past the top of memory counts as out of range, never a wrap.
    if (!stall_i) begin
      if (redirect && (cand[1:0] != 2'b00)) begin
        fault_o = FAULT_MISALIGN;
      end else if (cand_carry || !in_range(cand, ADDR_W)) begin
        fault_o = FAULT_RANGE;
      end else begin
        pc_d_o = cand;
      end
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: streams a program into instruction memory,
// then walks the pc until a halt instruction or a fault stops it.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       i_in,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  output logic [31:0]       pc,
  output logic              i_valid,
  output logic              halted,
  output logic [1:0]        fault
);

  state_e          state_q;
  logic [ADDR_W:0] cnt_q;
  logic [31:0]     pc_q;
  logic [1:0]      fault_q;

  logic [31:0]     pc_d;
  logic [1:0]      sel_fault;
  logic            load_full;
  logic            halt_hit;

  pc_next_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_sel (
    .pc_i            (pc_q),
    .stall_i         (stall),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .pc_d_o          (pc_d),
    .fault_o         (sel_fault)
  );

  // The counter's top bit set means every memory word has been written.
  assign load_full = cnt_q[ADDR_W];

  assign ld_ready  = (state_q == ST_LOAD);
  assign mem_we    = ld_ready && ld_valid && !load_full;
  assign mem_waddr = cnt_q[ADDR_W-1:0];
  assign mem_wdata = ld_data;

  assign pc        = pc_q;
  assign i_valid   = (state_q == ST_RUN) && in_range(pc_q, ADDR_W);
  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;

  assign halt_hit  = i_valid && !stall && (i_in == HALT_INSTR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      fault_q <= FAULT_NONE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_valid) begin
            if (load_full) begin
              if (fault_q == FAULT_NONE) fault_q <= FAULT_LOAD_OVF;
              state_q <= ST_HALT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (ld_last) begin
                state_q <= ST_RUN;
                pc_q    <= RESET_PC;
              end
            end
          end
        end
        ST_RUN: begin
          // A halt instruction stops fetch before any redirect is considered.
          if (halt_hit) begin
            state_q <= ST_HALT;
          end else if (sel_fault != FAULT_NONE) begin
            if (fault_q == FAULT_NONE) fault_q <= sel_fault;
            state_q <= ST_HALT;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: expected outputs are queued with each
// stimulus cycle and compared at the following falling edge.
module tb_fetch_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid, ld_last, stall, branch_taken, jump;
  logic [31:0] ld_data, i_in, branch_target, jump_target;

  logic        ld_ready, mem_we, i_valid, halted;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata, pc;
  logic [1:0]  fault;

  logic        s_ld_ready, s_mem_we, s_i_valid, s_halted;
  logic [1:0]  s_mem_waddr;
  logic [31:0] s_mem_wdata, s_pc;
  logic [1:0]  s_fault;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          sm;
    string       tag;
    logic [31:0] pc;
    logic        iv;
    logic        hl;
    logic [1:0]  flt;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rdy;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  fetch_seq #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .i_in(i_in), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .pc(pc), .i_valid(i_valid), .halted(halted), .fault(fault)
  );

  fetch_seq #(.ADDR_W(2), .RESET_PC(32'h0)) dut_s (
    .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(s_ld_ready), .mem_we(s_mem_we), .mem_waddr(s_mem_waddr),
    .mem_wdata(s_mem_wdata), .i_in(i_in), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .pc(s_pc), .i_valid(s_i_valid), .halted(s_halted), .fault(s_fault)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic push(input bit sm, input string tag, input logic [31:0] p, input logic iv,
                      input logic hl, input logic [1:0] flt, input logic we,
                      input logic [31:0] wa, input logic rdy);
    exp_t e;
    e.sm = sm; e.tag = tag; e.pc = p; e.iv = iv; e.hl = hl; e.flt = flt;
    e.we = we; e.wa = wa; e.wd = ld_data; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic tick_nochk();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    e = sb.pop_front();
    if (!e.sm) begin
      check_val({e.tag, ".pc"},  pc, e.pc);
      check_val({e.tag, ".iv"},  {31'd0, i_valid}, {31'd0, e.iv});
      check_val({e.tag, ".hl"},  {31'd0, halted}, {31'd0, e.hl});
      check_val({e.tag, ".flt"}, {30'd0, fault}, {30'd0, e.flt});
      check_val({e.tag, ".we"},  {31'd0, mem_we}, {31'd0, e.we});
      check_val({e.tag, ".rdy"}, {31'd0, ld_ready}, {31'd0, e.rdy});
      if (e.we) begin
        check_val({e.tag, ".wa"}, {22'd0, mem_waddr}, e.wa);
        check_val({e.tag, ".wd"}, mem_wdata, e.wd);
      end
    end else begin
      check_val({e.tag, ".pc"},  s_pc, e.pc);
      check_val({e.tag, ".iv"},  {31'd0, s_i_valid}, {31'd0, e.iv});
      check_val({e.tag, ".hl"},  {31'd0, s_halted}, {31'd0, e.hl});
      check_val({e.tag, ".flt"}, {30'd0, s_fault}, {30'd0, e.flt});
      check_val({e.tag, ".we"},  {31'd0, s_mem_we}, {31'd0, e.we});
      check_val({e.tag, ".rdy"}, {31'd0, s_ld_ready}, {31'd0, e.rdy});
      if (e.we) begin
        check_val({e.tag, ".wa"}, {30'd0, s_mem_waddr}, e.wa);
        check_val({e.tag, ".wd"}, s_mem_wdata, e.wd);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ld_valid = 0; ld_last = 0; ld_data = '0; i_in = '0; stall = 0;
    branch_taken = 0; branch_target = '0; jump = 0; jump_target = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick_nochk();
    reset = 0;
  endtask

  task automatic load_word(input bit sm, input string tag, input logic [31:0] d,
                           input logic last, input int addr);
    ld_valid = 1; ld_data = d; ld_last = last;
    push(sm, tag, 32'h0, 0, 0, 2'd0, 1, addr, 1);
    tick();
  endtask

  initial begin
    reset = 1;
    idle();
    tick_nochk();
    tick_nochk();
    reset = 0;

    // Reset state, then a 3-word load and sequential fetch.
    push(0, "rst", 32'h0, 0, 0, 2'd0, 0, 0, 1);
    tick();
    load_word(0, "ld0", 32'h1111_0000, 0, 0);
    load_word(0, "ld1", 32'h2222_0001, 0, 1);
    load_word(0, "ld2", 32'h3333_0002, 1, 2);
    idle();
    push(0, "run0", 32'h0, 1, 0, 2'd0, 0, 0, 0); tick();
    push(0, "run4", 32'h4, 1, 0, 2'd0, 0, 0, 0); tick();

    // Stall holds pc even with a branch pending.
    stall = 1; branch_taken = 1; branch_target = 32'h20;
    push(0, "stl_a", 32'h8, 1, 0, 2'd0, 0, 0, 0); tick();
    push(0, "stl_b", 32'h8, 1, 0, 2'd0, 0, 0, 0); tick();
    idle();
    push(0, "stl_c", 32'h8, 1, 0, 2'd0, 0, 0, 0); tick();

    // Jump beats branch.
    jump = 1; jump_target = 32'h10; branch_taken = 1; branch_target = 32'h20;
    push(0, "jb_pre", 32'hC, 1, 0, 2'd0, 0, 0, 0); tick();
    idle();
    branch_taken = 1; branch_target = 32'hC;
    push(0, "jb_jmp", 32'h10, 1, 0, 2'd0, 0, 0, 0); tick();

    // Halt instruction at 0xC.
    idle();
    i_in = 32'hFC00_0000;
    push(0, "hlt_pre", 32'hC, 1, 0, 2'd0, 0, 0, 0); tick();
    idle();
    jump = 1; jump_target = 32'h0;
    push(0, "hlt", 32'hC, 0, 1, 2'd0, 0, 0, 0); tick();
    push(0, "hlt_hold", 32'hC, 0, 1, 2'd0, 0, 0, 0); tick();

    // Misaligned branch target.
    do_reset();
    push(0, "rst2", 32'h0, 0, 0, 2'd0, 0, 0, 1); tick();
    load_word(0, "mis_ld", 32'hABCD_0000, 1, 0);
    idle();
    branch_taken = 1; branch_target = 32'h6;
    push(0, "mis_pre", 32'h0, 1, 0, 2'd0, 0, 0, 0); tick();
    idle();
    jump = 1; jump_target = 32'h10;
    push(0, "mis_flt", 32'h0, 0, 1, 2'd2, 0, 0, 0); tick();
    push(0, "mis_hold", 32'h0, 0, 1, 2'd2, 0, 0, 0); tick();

    // Sequential step past the last word.
    do_reset();
    push(0, "rst3", 32'h0, 0, 0, 2'd0, 0, 0, 1); tick();
    load_word(0, "rng_ld", 32'h0000_0001, 1, 0);
    idle();
    jump = 1; jump_target = 32'hFFC;
    push(0, "rng_pre", 32'h0, 1, 0, 2'd0, 0, 0, 0); tick();
    idle();
    push(0, "rng_last", 32'hFFC, 1, 0, 2'd0, 0, 0, 0); tick();
    push(0, "rng_flt", 32'hFFC, 0, 1, 2'd3, 0, 0, 0); tick();

    // Load overflow on the 4-word instance.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_word(1, $sformatf("ovf_ld%0d", i), 32'h5000_0000 + i, 0, i);
    end
    ld_valid = 1; ld_data = 32'h5000_0004; ld_last = 0;
    push(1, "ovf_5th", 32'h0, 0, 0, 2'd0, 0, 0, 1); tick();
    idle();
    push(1, "ovf_flt", 32'h0, 0, 1, 2'd1, 0, 0, 0); tick();

    // Reset in the middle of a load restarts at address 0.
    do_reset();
    load_word(0, "mid0", 32'h7000_0000, 0, 0);
    load_word(0, "mid1", 32'h7000_0001, 0, 1);
    ld_valid = 1; ld_data = 32'h7000_0002; reset = 1;
    tick_nochk();
    reset = 0;
    load_word(0, "mid_re0", 32'h7000_00A0, 0, 0);
    load_word(0, "mid_re1", 32'h7000_00A1, 1, 1);
    idle();
    push(0, "mid_run", 32'h0, 1, 0, 2'd0, 0, 0, 0); tick();

    check_val("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
